// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: RV32 opcode constants used by the hazard
// logic, the MUL/DIV funct7 encoding and the stall controller state type.
package pipeline_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_STALL,
    HZ_MDU_WAIT
  } hz_state_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational hazard decode for the stall controller.
// Ports:
//   instr_id    - instruction in ID (source register side)
//   instr_ex    - instruction in EX (producer side)
//   is_producer - EX writes a non-zero rd
//   is_load     - EX is a load
//   is_mdu      - EX is a MUL/DIV op
//   is_jalr_id  - ID is JALR
//   uses_rs1/2  - ID reads rs1/rs2
//   dep_rs1/2   - ID source matches EX producer rd
module hazard_decode
  import pipeline_pkg::*;
(
  input  logic [31:0] instr_id,
  input  logic [31:0] instr_ex,
  output logic        is_producer,
  output logic        is_load,
  output logic        is_mdu,
  output logic        is_jalr_id,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        dep_rs1,
  output logic        dep_rs2
);

  logic [6:0] ex_opc;
  logic [4:0] ex_rd;
  logic [6:0] ex_f7;
  logic [6:0] id_opc;
  logic [2:0] id_f3;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       unused_fields;

  assign ex_opc = instr_ex[6:0];
  assign ex_rd  = instr_ex[11:7];
  assign ex_f7  = instr_ex[31:25];
  assign id_opc = instr_id[6:0];
  assign id_f3  = instr_id[14:12];
  assign id_rs1 = instr_id[19:15];
  assign id_rs2 = instr_id[24:20];

  assign unused_fields = ^{instr_ex[24:12], instr_id[31:25], instr_id[11:7]};

  assign is_producer = (ex_rd != '0) &&
                       (ex_opc inside {OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
                                       OPC_AUIPC, OPC_JAL, OPC_JALR});
  assign is_load     = (ex_opc == OPC_LOAD);
  assign is_mdu      = (ex_opc == OPC_OP) && (ex_f7 == FUNCT7_MULDIV);
  assign is_jalr_id  = (id_opc == OPC_JALR) && (id_f3 == 3'b000);
  assign uses_rs1    = !(id_opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  assign uses_rs2    = id_opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
  assign dep_rs1     = is_producer && uses_rs1 && (id_rs1 == ex_rd);
  assign dep_rs2     = is_producer && uses_rs2 && (id_rs2 == ex_rd);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble/flush sequencer for the 5-stage RV32 core.
// Handles load-use, JALR-after-producer, multi-cycle MDU and EX redirects.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   instr_IF_ID/instr_ID_EX - instructions in ID and EX
//   redirect_EX             - taken control transfer resolved in EX
//   mdu_done                - MDU result valid pulse
//   pc_en/if_id_en/id_ex_en - pipeline register enables
//   flush_if_id/id_ex/ex_mem- NOP insertion controls
//   mdu_start               - MDU launch pulse
//   mdu_error               - sticky MDU timeout flag
// Optional: define HAZARD_PERF_EN to add stall_cycles / flush_events counters.
module hazard_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int TMO_W       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_IF_ID,
  input  logic [31:0] instr_ID_EX,
  input  logic        redirect_EX,
  input  logic        mdu_done,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        mdu_start,
  output logic        mdu_error
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  // wait_cnt is compared before its increment, so the last permitted wait
  // cycle is the one whose post-increment value reaches MDU_TIMEOUT-1.
  localparam logic [TMO_W-1:0] WAIT_LAST = TMO_W'(MDU_TIMEOUT - 2);

  hz_state_t        state, state_next;
  logic [1:0]       stall_cnt, stall_cnt_next;
  logic [TMO_W-1:0] wait_cnt, wait_cnt_next;
  logic             err_set;

  logic is_producer, is_load, is_mdu, is_jalr_id;
  logic uses_rs1, uses_rs2, dep_rs1, dep_rs2;

  hazard_decode u_decode (
    .instr_id    (instr_IF_ID),
    .instr_ex    (instr_ID_EX),
    .is_producer (is_producer),
    .is_load     (is_load),
    .is_mdu      (is_mdu),
    .is_jalr_id  (is_jalr_id),
    .uses_rs1    (uses_rs1),
    .uses_rs2    (uses_rs2),
    .dep_rs1     (dep_rs1),
    .dep_rs2     (dep_rs2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HZ_RUN;
      stall_cnt <= '0;
      wait_cnt  <= '0;
      mdu_error <= 1'b0;
    end else begin
      state     <= state_next;
      stall_cnt <= stall_cnt_next;
      wait_cnt  <= wait_cnt_next;
      if (err_set) mdu_error <= 1'b1;
    end
  end

  // Outputs are held at RUN defaults while reset is asserted so a stale MDU
  // op still sitting in EX cannot raise mdu_start or a stall during reset.
  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    flush_ex_mem   = 1'b0;
    mdu_start      = 1'b0;
    state_next     = state;
    stall_cnt_next = stall_cnt;
    wait_cnt_next  = wait_cnt;
    err_set        = 1'b0;
    if (rst_n) begin
      unique case (state)
        HZ_RUN: begin
          if (redirect_EX) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (is_mdu) begin
            mdu_start     = 1'b1;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            flush_ex_mem  = 1'b1;
            wait_cnt_next = '0;
            state_next    = HZ_MDU_WAIT;
          end else if (is_jalr_id && dep_rs1) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            flush_id_ex = 1'b1;
            if (is_load) begin
              stall_cnt_next = 2'd1;
              state_next     = HZ_STALL;
            end
          end else if (is_load && (dep_rs1 || dep_rs2)) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            flush_id_ex = 1'b1;
          end
        end
        HZ_STALL: begin
          if (redirect_EX) begin
            flush_if_id    = 1'b1;
            flush_id_ex    = 1'b1;
            stall_cnt_next = '0;
            state_next     = HZ_RUN;
          end else begin
            pc_en          = 1'b0;
            if_id_en       = 1'b0;
            flush_id_ex    = 1'b1;
            stall_cnt_next = stall_cnt - 2'd1;
            if (stall_cnt == 2'd1) state_next = HZ_RUN;
          end
        end
        HZ_MDU_WAIT: begin
          if (mdu_done) begin
            state_next = HZ_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            // Abort: pipeline resumes but the missing result is squashed.
            flush_ex_mem = 1'b1;
            err_set      = 1'b1;
            state_next   = HZ_RUN;
          end else begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            flush_ex_mem  = 1'b1;
            wait_cnt_next = wait_cnt + 1'b1;
          end
        end
        default: state_next = HZ_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en)      stall_cycles <= stall_cycles + 32'd1;
      if (flush_if_id) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule
